// File: rtl/alu_operand_stage_pkg.sv
// Shared select codes and stage state encoding for the ALU operand stage.
// The named source codes are also used by the control unit when it builds sel_a/sel_b.
package alu_operand_stage_pkg;

  localparam int SEL_W_DEFAULT = 4;

  localparam logic [SEL_W_DEFAULT-1:0] SEL_ZERO     = 4'd0;
  localparam logic [SEL_W_DEFAULT-1:0] SEL_IDR1     = 4'd1;
  localparam logic [SEL_W_DEFAULT-1:0] SEL_MDR      = 4'd2;
  localparam logic [SEL_W_DEFAULT-1:0] SEL_RCOL     = 4'd3;
  localparam logic [SEL_W_DEFAULT-1:0] SEL_RROW     = 4'd4;
  localparam logic [SEL_W_DEFAULT-1:0] SEL_RI       = 4'd5;
  localparam logic [SEL_W_DEFAULT-1:0] SEL_RJ       = 4'd6;
  localparam logic [SEL_W_DEFAULT-1:0] SEL_RTOTAL   = 4'd7;
  localparam logic [SEL_W_DEFAULT-1:0] SEL_RADDR    = 4'd8;
  localparam logic [SEL_W_DEFAULT-1:0] SEL_RBND     = 4'd9;
  localparam logic [SEL_W_DEFAULT-1:0] SEL_RCOLTEMP = 4'd10;
  localparam logic [SEL_W_DEFAULT-1:0] SEL_FWD      = '1;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

endpackage

// File: rtl/alu_operand_decode.sv
// Combinational select decode for one ALU operand: zero, one of NSRC sources,
// or (with ALU_FWD_EN) the forwarded ALU result on the all-ones code.
module operand_decode #(
  parameter int W    = 18,
  parameter int NSRC = 10,
  parameter int SELW = 4
) (
  input  logic [SELW-1:0]   sel,
  input  logic [NSRC*W-1:0] src_bus,
  input  logic [W-1:0]      fwd_data,
  input  logic              fwd_valid,
  output logic [W-1:0]      operand,
  output logic              illegal
);

  // NOTE: every output gets a default at the top of always_comb so no path
  // through the block leaves it unassigned, which would infer a latch.
  always_comb begin
    operand = '0;
    illegal = (sel != '0);
    for (int k = 1; k <= NSRC; k++) begin
      if (sel == SELW'(k)) begin
        operand = src_bus[(k-1)*W +: W];
        illegal = 1'b0;
      end
    end
`ifdef ALU_FWD_EN
    // A forward request with no valid result reads as zero and stays flagged.
    if (sel == '1 && fwd_valid) begin
      operand = fwd_data;
      illegal = 1'b0;
    end
`endif
  end

`ifndef ALU_FWD_EN
  logic unused_fwd;
  assign unused_fwd = ^{fwd_data, fwd_valid};
`endif

endmodule

// File: rtl/alu_operand_stage.sv
// Registered ALU operand selector: decodes A/B from the source bus and holds the
// pair behind a valid/ready handshake with a 2-entry skid buffer. Option: ALU_FWD_EN.
module alu_operand_stage
  import alu_operand_stage_pkg::*;
#(
  parameter int W    = 18,
  parameter int NSRC = 10,
  parameter int SELW = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NSRC*W-1:0] src_bus,
  input  logic [SELW-1:0]   sel_a,
  input  logic [SELW-1:0]   sel_b,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [W-1:0]      alu_a,
  output logic [W-1:0]      alu_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              sel_err,
  input  logic              err_clr,
  input  logic [W-1:0]      fwd_data,
  input  logic              fwd_valid
);

  logic [W-1:0] dec_a, dec_b;
  logic         ill_a, ill_b;

  operand_decode #(.W(W), .NSRC(NSRC), .SELW(SELW)) u_dec_a (
    .sel       (sel_a),
    .src_bus   (src_bus),
    .fwd_data  (fwd_data),
    .fwd_valid (fwd_valid),
    .operand   (dec_a),
    .illegal   (ill_a)
  );

  operand_decode #(.W(W), .NSRC(NSRC), .SELW(SELW)) u_dec_b (
    .sel       (sel_b),
    .src_bus   (src_bus),
    .fwd_data  (fwd_data),
    .fwd_valid (fwd_valid),
    .operand   (dec_b),
    .illegal   (ill_b)
  );

  logic [1:0]   state, state_next;
  logic [W-1:0] main_a, main_b, skid_a, skid_b;
  logic         accept, xfer;
  logic         load_main_dec, load_main_skid, load_skid;

  assign accept    = in_valid && in_ready;
  assign xfer      = out_valid && out_ready;
  assign out_valid = (state != ST_EMPTY);
  assign alu_a     = main_a;
  assign alu_b     = main_b;

  always_comb begin
    state_next     = state;
    load_main_dec  = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (state)
      ST_EMPTY: begin
        if (accept) begin
          load_main_dec = 1'b1;
          state_next    = ST_ONE;
        end
      end
      ST_ONE: begin
        if (accept && xfer) begin
          load_main_dec = 1'b1;
        end else if (accept) begin
          load_skid  = 1'b1;
          state_next = ST_FULL;
        end else if (xfer) begin
          state_next = ST_EMPTY;
        end
      end
      ST_FULL: begin
        // in_ready is low here, so only the drain of main can happen.
        if (xfer) begin
          load_main_skid = 1'b1;
          state_next     = ST_ONE;
        end
      end
      default: state_next = ST_EMPTY;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order. The skid registers are
  // reset too, so nothing captured before a reset can ever reach the outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_EMPTY;
      in_ready <= 1'b1;
      main_a   <= '0;
      main_b   <= '0;
      skid_a   <= '0;
      skid_b   <= '0;
      sel_err  <= 1'b0;
    end else begin
      state    <= state_next;
      in_ready <= (state_next != ST_FULL);
      if (load_main_dec) begin
        main_a <= dec_a;
        main_b <= dec_b;
      end else if (load_main_skid) begin
        main_a <= skid_a;
        main_b <= skid_b;
      end
      if (load_skid) begin
        skid_a <= dec_a;
        skid_b <= dec_b;
      end
      // Set has priority over a same-cycle clear.
      if (accept && (ill_a || ill_b)) begin
        sel_err <= 1'b1;
      end else if (err_clr) begin
        sel_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed self-checking bench for alu_operand_stage; expectations are hand-computed
// from source k = 18'h100 + k (source index k selected by code k+1).
module tb_alu_operand_stage;

  localparam int W    = 18;
  localparam int NSRC = 10;
  localparam int SELW = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NSRC*W-1:0] src_bus;
  logic [SELW-1:0]   sel_a, sel_b;
  logic              in_valid, in_ready;
  logic [W-1:0]      alu_a, alu_b;
  logic              out_valid, out_ready;
  logic              sel_err, err_clr;
  logic [W-1:0]      fwd_data;
  logic              fwd_valid;

  int n_checks = 0;
  int n_fail   = 0;

  alu_operand_stage #(.W(W), .NSRC(NSRC), .SELW(SELW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .src_bus   (src_bus),
    .sel_a     (sel_a),
    .sel_b     (sel_b),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sel_err   (sel_err),
    .err_clr   (err_clr),
    .fwd_data  (fwd_data),
    .fwd_valid (fwd_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [SELW-1:0] a, input logic [SELW-1:0] b);
    sel_a    = a;
    sel_b    = b;
    in_valid = 1'b1;
  endtask

  initial begin
    rst_n     = 1'b0;
    sel_a     = '0;
    sel_b     = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    err_clr   = 1'b0;
    fwd_data  = '0;
    fwd_valid = 1'b0;
    for (int k = 0; k < NSRC; k++) src_bus[k*W +: W] = W'(18'h100 + k);

    step();
    step();
    check("rst_alu_a", alu_a, 0);
    check("rst_alu_b", alu_b, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_sel_err", sel_err, 0);
    rst_n = 1'b1;

    // Single pair, latency one cycle.
    out_ready = 1'b1;
    offer(4'd3, 4'd7);
    step();
    in_valid = 1'b0;
    check("t1_alu_a", alu_a, 18'h102);
    check("t1_alu_b", alu_b, 18'h106);
    check("t1_out_valid", out_valid, 1);
    step();
    check("t1_drain", out_valid, 0);

    // Stall: fill both entries, third pair held off.
    out_ready = 1'b0;
    offer(4'd1, 4'd2);
    step();
    check("t2_ready_one", in_ready, 1);
    offer(4'd4, 4'd5);
    step();
    check("t2_ready_full", in_ready, 0);
    offer(4'd9, 4'd10);
    step();
    check("t2_ready_hold", in_ready, 0);
    check("t2_stable_a", alu_a, 18'h100);
    check("t2_stable_b", alu_b, 18'h101);
    out_ready = 1'b1;
    step();
    check("t2_p2_a", alu_a, 18'h103);
    check("t2_p2_b", alu_b, 18'h104);
    check("t2_p2_valid", out_valid, 1);
    step();
    in_valid = 1'b0;
    check("t2_p3_a", alu_a, 18'h108);
    check("t2_p3_b", alu_b, 18'h109);
    step();
    check("t2_drain", out_valid, 0);

    // Illegal select and sticky error.
    offer(4'd0, 4'd12);
    step();
    in_valid = 1'b0;
    check("t3_alu_a", alu_a, 0);
    check("t3_alu_b", alu_b, 0);
    check("t3_err_set", sel_err, 1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("t3_err_clr", sel_err, 0);
    err_clr = 1'b1;
    offer(4'd13, 4'd1);
    step();
    err_clr  = 1'b0;
    in_valid = 1'b0;
    check("t3_set_wins", sel_err, 1);
    check("t3_b_legal", alu_b, 18'h100);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("t3_err_clr2", sel_err, 0);

    // Fill to FULL, ignored illegal offer, then reset mid-cycle.
    out_ready = 1'b0;
    offer(4'd1, 4'd2);
    step();
    offer(4'd3, 4'd4);
    step();
    offer(4'd14, 4'd14);
    step();
    check("t4_unaccepted_err", sel_err, 0);
    check("t4_full", in_ready, 0);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("t4_rst_a", alu_a, 0);
    check("t4_rst_b", alu_b, 0);
    check("t4_rst_valid", out_valid, 0);
    check("t4_rst_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    offer(4'd5, 4'd6);
    step();
    in_valid = 1'b0;
    check("t4_post_a", alu_a, 18'h104);
    check("t4_post_b", alu_b, 18'h105);
    out_ready = 1'b1;
    step();
    check("t4_no_stale", out_valid, 0);

    // Forward code.
    fwd_valid = 1'b1;
    fwd_data  = 18'h3FFFF;
    offer(4'hF, 4'd2);
    step();
    in_valid  = 1'b0;
    fwd_valid = 1'b0;
    check("t5_alu_b", alu_b, 18'h101);
`ifdef ALU_FWD_EN
    check("t5_fwd_a", alu_a, 18'h3FFFF);
    check("t5_fwd_err", sel_err, 0);
`else
    check("t5_fwd_a", alu_a, 0);
    check("t5_fwd_err", sel_err, 1);
`endif
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("t5_err_clr", sel_err, 0);

    // Back-to-back throughput.
    for (int i = 0; i < 8; i++) begin
      offer(SELW'(i + 1), SELW'(8 - i));
      step();
      check($sformatf("t6_a%0d", i), alu_a, 18'h100 + i);
      check($sformatf("t6_b%0d", i), alu_b, 18'h107 - i);
      check($sformatf("t6_v%0d", i), out_valid, 1);
      check($sformatf("t6_r%0d", i), in_ready, 1);
    end
    in_valid = 1'b0;
    step();
    check("t6_drain", out_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
